// File: rtl/exc_stage_pipe_pkg.sv
// exc_stage_pipe_pkg: shared exception bundle layout, field offsets, exccodes and memory-size encodings
// Exports EXC_W, OFF_* bit offsets of the bundle, EXCCODE_*, MSIZE_*, exc_t and misaligned().
package exc_stage_pipe_pkg;

    localparam int EXC_W = 58;

    localparam int OFF_DETECT_OF     = 0;
    localparam int OFF_EXCCODE       = 1;
    localparam int OFF_ERET          = 6;
    localparam int OFF_BD            = 7;
    localparam int OFF_OV            = 8;
    localparam int OFF_RI            = 9;
    localparam int OFF_BP            = 10;
    localparam int OFF_SYS           = 11;
    localparam int OFF_ADES          = 12;
    localparam int OFF_ADEL          = 13;
    localparam int OFF_EXC_DATA      = 14;
    localparam int OFF_EXC_INSTR     = 15;
    localparam int OFF_EXC_RESERVED  = 16;
    localparam int OFF_EXC_FETCH     = 17;
    localparam int OFF_EXC_INT       = 18;
    localparam int OFF_BADADDR       = 19;
    localparam int OFF_ADDR_CP0      = 51;
    localparam int OFF_READ_CP0      = 56;
    localparam int OFF_SET_CP0       = 57;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [1:0] MSIZE_BYTE = 2'd0;
    localparam logic [1:0] MSIZE_HALF = 2'd1;
    localparam logic [1:0] MSIZE_WORD = 2'd2;

    // Field order matches the OFF_* offsets, MSB first.
    typedef struct packed {
        logic        set_cp0;
        logic        read_cp0;
        logic [4:0]  addr_cp0;
        logic [31:0] badaddr;
        logic        exc_int;
        logic        exc_fetch;
        logic        exc_reserved;
        logic        exc_instruction;
        logic        exc_data;
        logic        adel;
        logic        ades;
        logic        sys;
        logic        bp;
        logic        ri;
        logic        ov;
        logic        bd;
        logic        eret;
        logic [4:0]  exccode;
        logic        detect_of;
    } exc_t;

    function automatic logic misaligned(input logic [1:0] msize, input logic [1:0] addr);
        return (msize == MSIZE_HALF && addr[0]) || (msize == MSIZE_WORD && addr != 2'b00);
    endfunction

endpackage

// File: rtl/exc_stage_pipe_if.sv
// exc_stage_pipe_if: ID/EX/MEM handshake and exception signals around exc_stage_pipe
// slave = the exception pipe itself, master = the surrounding pipeline and CP0 block.
interface exc_stage_pipe_if;
    import exc_stage_pipe_pkg::*;

    logic        flush;
    logic        int_detect;
    logic        id_valid;
    logic        ex_allowin;
    logic [31:0] id_pc;
    logic        id_bd;
    logic        id_fetch_adel;
    logic        id_ri;
    logic        id_sys;
    logic        id_bp;
    logic        id_eret;
    logic        id_mtc0;
    logic        id_mfc0;
    logic [4:0]  id_cp0_addr;
    logic        id_detect_of;
    logic        id_load;
    logic        id_store;
    logic [1:0]  id_msize;
    logic        ex_ready_go;
    logic        ex_alu_of;
    logic [31:0] ex_mem_addr;
    logic        ex_exc_pending;
    logic        mem_allowin;
    logic        mem_valid;
    logic [31:0] mem_pc;
    exc_t        mem_exc;

    modport master (
        output flush, int_detect, id_valid, id_pc, id_bd, id_fetch_adel, id_ri, id_sys, id_bp,
               id_eret, id_mtc0, id_mfc0, id_cp0_addr, id_detect_of, id_load, id_store, id_msize,
               ex_ready_go, ex_alu_of, ex_mem_addr, mem_allowin,
        input  ex_allowin, ex_exc_pending, mem_valid, mem_pc, mem_exc
    );

    modport slave (
        input  flush, int_detect, id_valid, id_pc, id_bd, id_fetch_adel, id_ri, id_sys, id_bp,
               id_eret, id_mtc0, id_mfc0, id_cp0_addr, id_detect_of, id_load, id_store, id_msize,
               ex_ready_go, ex_alu_of, ex_mem_addr, mem_allowin,
        output ex_allowin, ex_exc_pending, mem_valid, mem_pc, mem_exc
    );

endinterface

// File: rtl/exc_stage_pipe_reg.sv
// exc_stage_pipe_reg: valid + payload + pc pipeline register with load, drain, flush and sync reset
// ld writes payload/pc and sets valid; clr drops valid when the stage moves on; upd rewrites payload only.
module exc_stage_pipe_reg #(
    parameter int          W      = 58,
    parameter logic [31:0] RST_PC = 32'hBFC00000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         ld,
    input  logic         clr,
    input  logic         upd,
    input  logic [W-1:0] din,
    input  logic [31:0]  pin,
    output logic         valid_q,
    output logic [W-1:0] data_q,
    output logic [31:0]  pc_q
);

    logic         valid_d;
    logic [W-1:0] data_d;
    logic [31:0]  pc_d;

    always_comb begin
        valid_d = !flush && (ld || (valid_q && !clr));
        data_d  = (ld || upd) ? din : data_q;
        pc_d    = ld ? pin : pc_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= RST_PC;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/exc_stage_pipe.sv
// exc_stage_pipe: carries exception info ID->EX->MEM, adds EX overflow/data-address faults and resolves priority
// Ports: clk, resetn (sync active-low), bus (exc_stage_pipe_if.slave: ID inputs, EX status, MEM bundle out).
module exc_stage_pipe
    import exc_stage_pipe_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              resetn,
    exc_stage_pipe_if.slave   bus
);

    // EX needs the memory-op kind on top of the bundle to detect data faults.
    typedef struct packed {
        logic       load;
        logic       store;
        logic [1:0] msize;
        exc_t       exc;
    } ex_t;

    ex_t         id_cap, ex_hold, ex_din, ex_q;
    exc_t        e, mem_din, mem_q;
    logic        ex_valid, mem_valid, ex_ld, ex_go;
    logic [31:0] ex_pc, mem_pc;
    logic        ov, mis, c_int, c_fetch, c_res, c_ins, c_data, any_exc, mem_any;

    assign bus.ex_allowin = !ex_valid || (bus.ex_ready_go && bus.mem_allowin);
    assign ex_ld          = bus.id_valid && bus.ex_allowin;
    assign ex_go          = ex_valid && bus.ex_ready_go && bus.mem_allowin;

    always_comb begin
        id_cap                       = '0;
        id_cap.load                  = bus.id_load;
        id_cap.store                 = bus.id_store;
        id_cap.msize                 = bus.id_msize;
        id_cap.exc.set_cp0           = bus.id_mtc0;
        id_cap.exc.read_cp0          = bus.id_mfc0;
        id_cap.exc.addr_cp0          = bus.id_cp0_addr;
        id_cap.exc.badaddr           = bus.id_fetch_adel ? bus.id_pc : 32'h0;
        id_cap.exc.exc_int           = bus.int_detect;
        id_cap.exc.exc_fetch         = bus.id_fetch_adel;
        id_cap.exc.adel              = bus.id_fetch_adel;
        id_cap.exc.ri                = bus.id_ri;
        id_cap.exc.sys               = bus.id_sys;
        id_cap.exc.bp                = bus.id_bp;
        id_cap.exc.eret              = bus.id_eret;
        id_cap.exc.bd                = bus.id_bd;
        id_cap.exc.detect_of         = bus.id_detect_of;
        // A held EX instruction keeps everything except a pending interrupt, which latches on.
        ex_hold                      = ex_q;
        ex_hold.exc.exc_int          = ex_q.exc.exc_int || bus.int_detect;
        ex_din                       = ex_ld ? id_cap : ex_hold;
    end

    exc_stage_pipe_reg #(.W($bits(ex_t)), .RST_PC(RST_PC)) u_id_ex (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (bus.flush),
        .ld      (ex_ld),
        .clr     (bus.ex_ready_go && bus.mem_allowin),
        .upd     (bus.int_detect),
        .din     (ex_din),
        .pin     (bus.id_pc),
        .valid_q (ex_valid),
        .data_q  (ex_q),
        .pc_q    (ex_pc)
    );

    // Exactly one class survives: int > fetch > reserved > instruction > data.
    always_comb begin
        e       = ex_q.exc;
        ov      = e.detect_of && bus.ex_alu_of;
        mis     = misaligned(ex_q.msize, bus.ex_mem_addr[1:0]);
        c_int   = e.exc_int || bus.int_detect;
        c_fetch = !c_int && e.exc_fetch;
        c_res   = !c_int && !c_fetch && e.ri;
        c_ins   = !c_int && !c_fetch && !c_res && (e.sys || e.bp || ov);
        c_data  = !c_int && !c_fetch && !c_res && !c_ins && (ex_q.load || ex_q.store) && mis;
        any_exc = c_int || c_fetch || c_res || c_ins || c_data;
        mem_din                 = '0;
        mem_din.set_cp0         = e.set_cp0 && !any_exc;
        mem_din.read_cp0        = e.read_cp0;
        mem_din.addr_cp0        = e.addr_cp0;
        mem_din.badaddr         = c_data ? bus.ex_mem_addr : e.badaddr;
        mem_din.exc_int         = c_int;
        mem_din.exc_fetch       = c_fetch;
        mem_din.exc_reserved    = c_res;
        mem_din.exc_instruction = c_ins;
        mem_din.exc_data        = c_data;
        mem_din.adel            = c_fetch || (c_data && ex_q.load);
        mem_din.ades            = c_data && ex_q.store;
        mem_din.sys             = c_ins && e.sys;
        mem_din.bp              = c_ins && e.bp;
        mem_din.ri              = c_res;
        mem_din.ov              = c_ins && ov;
        mem_din.bd              = e.bd;
        mem_din.eret            = e.eret && !any_exc;
        mem_din.detect_of       = e.detect_of;
        mem_din.exccode         = c_fetch ? EXCCODE_ADEL :
                                  c_res   ? EXCCODE_RI :
                                  c_ins   ? (e.sys ? EXCCODE_SYS : e.bp ? EXCCODE_BP : EXCCODE_OV) :
                                  c_data  ? (ex_q.load ? EXCCODE_ADEL : EXCCODE_ADES) :
                                  EXCCODE_INT;
    end

    exc_stage_pipe_reg #(.W(EXC_W), .RST_PC(RST_PC)) u_ex_mem (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (bus.flush),
        .ld      (ex_go),
        .clr     (bus.mem_allowin),
        .upd     (1'b0),
        .din     (mem_din),
        .pin     (ex_pc),
        .valid_q (mem_valid),
        .data_q  (mem_q),
        .pc_q    (mem_pc)
    );

    assign mem_any = mem_q.exc_int || mem_q.exc_fetch || mem_q.exc_reserved ||
                     mem_q.exc_instruction || mem_q.exc_data;

    assign bus.ex_exc_pending = (ex_valid && any_exc) || (mem_valid && mem_any);
    assign bus.mem_valid      = mem_valid;
    assign bus.mem_pc         = mem_pc;
    assign bus.mem_exc        = mem_q;

endmodule

// File: tb/tb_exc_stage_pipe.sv
// tb_exc_stage_pipe: directed vector table plus stall, flush and reset sequences for exc_stage_pipe
module tb_exc_stage_pipe;
    import exc_stage_pipe_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    // f = {intr, fetch_adel, ri, sys, bp, eret, mtc0, detect_of, load, store}
    // cls = {int, fetch, reserved, instruction, data}; aao = {adel, ades, ov}; sep = {set_cp0, eret, pending}
    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  f;
        logic [1:0]  ms;
        logic        aof;
        logic [31:0] addr;
        logic [4:0]  cls;
        logic [4:0]  code;
        logic [2:0]  aao;
        logic [31:0] bad;
        logic [2:0]  sep;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errs = 0;
    int   checks = 0;
    vec_t v [17];
    exc_t m;

    exc_stage_pipe_if bus();

    exc_stage_pipe #(.RST_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    task automatic idle_id();
        bus.id_valid = 1'b0; bus.id_pc = 32'h0; bus.id_bd = 1'b0; bus.id_fetch_adel = 1'b0;
        bus.id_ri = 1'b0; bus.id_sys = 1'b0; bus.id_bp = 1'b0; bus.id_eret = 1'b0;
        bus.id_mtc0 = 1'b0; bus.id_mfc0 = 1'b0; bus.id_cp0_addr = 5'd0; bus.id_detect_of = 1'b0;
        bus.id_load = 1'b0; bus.id_store = 1'b0; bus.id_msize = MSIZE_WORD; bus.int_detect = 1'b0;
    endtask

    task automatic drive_id(input vec_t t);
        bus.id_valid = 1'b1; bus.id_pc = t.pc;
        {bus.int_detect, bus.id_fetch_adel, bus.id_ri, bus.id_sys, bus.id_bp, bus.id_eret,
         bus.id_mtc0, bus.id_detect_of, bus.id_load, bus.id_store} = t.f;
        bus.id_msize = t.ms; bus.id_cp0_addr = 5'd12;
    endtask

    task automatic plain(input logic [31:0] pc);
        vec_t t;
        t = '0;
        t.pc = pc;
        t.ms = MSIZE_WORD;
        drive_id(t);
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        drive_id(v[i]);
        bus.ex_ready_go = 1'b1; bus.mem_allowin = 1'b1;
        @(negedge clk);
        idle_id();
        bus.ex_alu_of = v[i].aof; bus.ex_mem_addr = v[i].addr;
        #1 chk($sformatf("v%0d pend", i), 64'(bus.ex_exc_pending), 64'(v[i].sep[0]));
        @(negedge clk);
        m = bus.mem_exc;
        chk($sformatf("v%0d mem_valid", i), 64'(bus.mem_valid), 64'd1);
        chk($sformatf("v%0d mem_pc", i), 64'(bus.mem_pc), 64'(v[i].pc));
        chk($sformatf("v%0d class", i), 64'({m.exc_int, m.exc_fetch, m.exc_reserved, m.exc_instruction, m.exc_data}), 64'(v[i].cls));
        chk($sformatf("v%0d exccode", i), 64'(m.exccode), 64'(v[i].code));
        chk($sformatf("v%0d adel_ades_ov", i), 64'({m.adel, m.ades, m.ov}), 64'(v[i].aao));
        chk($sformatf("v%0d badaddr", i), 64'(m.badaddr), 64'(v[i].bad));
        chk($sformatf("v%0d set_cp0", i), 64'(m.set_cp0), 64'(v[i].sep[2]));
        chk($sformatf("v%0d eret", i), 64'(m.eret), 64'(v[i].sep[1]));
        bus.ex_alu_of = 1'b0; bus.ex_mem_addr = 32'h0;
    endtask

    initial begin
        v[0]  = '{32'hBFC00010, 10'b0000000000, 2'd2, 1'b0, 32'h0,        5'b00000, 5'h00, 3'b000, 32'h0,        3'b000};
        v[1]  = '{32'hBFC00014, 10'b0000000010, 2'd2, 1'b0, 32'h80000002, 5'b00001, 5'h04, 3'b100, 32'h80000002, 3'b001};
        v[2]  = '{32'hBFC00018, 10'b0000000001, 2'd2, 1'b0, 32'h80000002, 5'b00001, 5'h05, 3'b010, 32'h80000002, 3'b001};
        v[3]  = '{32'hBFC0001C, 10'b0000000100, 2'd2, 1'b1, 32'h0,        5'b00010, 5'h0c, 3'b001, 32'h0,        3'b001};
        v[4]  = '{32'hBFC00011, 10'b0100000100, 2'd2, 1'b1, 32'h0,        5'b01000, 5'h04, 3'b100, 32'hBFC00011, 3'b001};
        v[5]  = '{32'hBFC00020, 10'b0010001000, 2'd2, 1'b0, 32'h0,        5'b00100, 5'h0a, 3'b000, 32'h0,        3'b001};
        v[6]  = '{32'hBFC00024, 10'b0000001000, 2'd2, 1'b0, 32'h0,        5'b00000, 5'h00, 3'b000, 32'h0,        3'b100};
        v[7]  = '{32'hBFC00028, 10'b0001000000, 2'd2, 1'b0, 32'h0,        5'b00010, 5'h08, 3'b000, 32'h0,        3'b001};
        v[8]  = '{32'hBFC0002C, 10'b0000100000, 2'd2, 1'b0, 32'h0,        5'b00010, 5'h09, 3'b000, 32'h0,        3'b001};
        v[9]  = '{32'hBFC00030, 10'b0000010000, 2'd2, 1'b0, 32'h0,        5'b00000, 5'h00, 3'b000, 32'h0,        3'b010};
        v[10] = '{32'hBFC00034, 10'b0010010000, 2'd2, 1'b0, 32'h0,        5'b00100, 5'h0a, 3'b000, 32'h0,        3'b001};
        v[11] = '{32'hBFC00038, 10'b0000000010, 2'd1, 1'b0, 32'h80000001, 5'b00001, 5'h04, 3'b100, 32'h80000001, 3'b001};
        v[12] = '{32'hBFC0003C, 10'b0000000010, 2'd1, 1'b0, 32'h80000002, 5'b00000, 5'h00, 3'b000, 32'h0,        3'b000};
        v[13] = '{32'hBFC00040, 10'b0000000001, 2'd0, 1'b0, 32'h80000003, 5'b00000, 5'h00, 3'b000, 32'h0,        3'b000};
        v[14] = '{32'hBFC00044, 10'b0000000000, 2'd2, 1'b1, 32'h0,        5'b00000, 5'h00, 3'b000, 32'h0,        3'b000};
        v[15] = '{32'hBFC00048, 10'b1000000010, 2'd2, 1'b0, 32'h80000002, 5'b10000, 5'h00, 3'b000, 32'h0,        3'b001};
        v[16] = '{32'hBFC00022, 10'b0100000010, 2'd2, 1'b0, 32'h80000001, 5'b01000, 5'h04, 3'b100, 32'hBFC00022, 3'b001};

        idle_id();
        bus.flush = 1'b0; bus.ex_ready_go = 1'b1; bus.mem_allowin = 1'b1;
        bus.ex_alu_of = 1'b0; bus.ex_mem_addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ex_allowin", 64'(bus.ex_allowin), 64'd1);
        chk("rst mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst mem_pc", 64'(bus.mem_pc), 64'(RST_PC));
        chk("rst mem_exc", 64'(bus.mem_exc), 64'd0);
        chk("rst pend", 64'(bus.ex_exc_pending), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i);

        // EX stall with an interrupt pulse mid-stall
        @(negedge clk);
        plain(32'hBFC00080);
        @(negedge clk);
        idle_id();
        bus.ex_ready_go = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.int_detect = (c == 2);
            #1;
            if (c == 1) chk("stall ex_allowin", 64'(bus.ex_allowin), 64'd0);
            if (c == 3) chk("stall sticky pend", 64'(bus.ex_exc_pending), 64'd1);
            if (c == 4) chk("stall mem_valid", 64'(bus.mem_valid), 64'd0);
            @(negedge clk);
        end
        bus.int_detect = 1'b0;
        bus.ex_ready_go = 1'b1;
        @(negedge clk);
        m = bus.mem_exc;
        chk("stall mem_valid out", 64'(bus.mem_valid), 64'd1);
        chk("stall mem_pc", 64'(bus.mem_pc), 64'hBFC00080);
        chk("stall exc_int", 64'(m.exc_int), 64'd1);
        chk("stall exccode", 64'(m.exccode), 64'd0);

        // flush while both loads are active
        @(negedge clk);
        plain(32'hBFC00100);
        @(negedge clk);
        plain(32'hBFC00104);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        idle_id();
        bus.mem_allowin = 1'b0;
        #1;
        chk("flush mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("flush ex_allowin", 64'(bus.ex_allowin), 64'd1);
        bus.mem_allowin = 1'b1;
        @(negedge clk);
        chk("flush no stale mem", 64'(bus.mem_valid), 64'd0);

        // full pipe, MEM back-pressure, then mid-stream reset
        plain(32'hBFC00200);
        @(negedge clk);
        plain(32'hBFC00204);
        @(negedge clk);
        idle_id();
        bus.mem_allowin = 1'b0;
        #1;
        chk("bp mem_valid", 64'(bus.mem_valid), 64'd1);
        chk("bp mem_pc", 64'(bus.mem_pc), 64'hBFC00200);
        chk("bp ex_allowin", 64'(bus.ex_allowin), 64'd0);
        @(negedge clk);
        chk("bp hold mem_pc", 64'(bus.mem_pc), 64'hBFC00200);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mid rst mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("mid rst ex_allowin", 64'(bus.ex_allowin), 64'd1);
        chk("mid rst mem_pc", 64'(bus.mem_pc), 64'(RST_PC));
        chk("mid rst mem_exc", 64'(bus.mem_exc), 64'd0);
        bus.mem_allowin = 1'b1;
        @(negedge clk);
        chk("mid rst no stale mem", 64'(bus.mem_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
